// File: rtl/fft256_pkg.sv
// Shared definitions for the FFT256 first-stage frame controller.
//   FFT_N / HALF_N : frame length and the commit point of the SDF stage
//   state_t        : input-side sequencer states
//   tag_t          : per-output-frame tag {frame index, aborted flag}
package fft256_pkg;

  localparam int unsigned FFT_N     = 256;
  localparam int unsigned HALF_N    = 128;
  localparam int unsigned TAG_IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ABORT,
    FLUSH
  } state_t;

  typedef struct packed {
    logic [TAG_IDX_W-1:0] idx;
    logic                 err;
  } tag_t;

endpackage

// File: rtl/fft256_tag_fifo.sv
// Two-entry tag FIFO between the input sequencer and the output tagger.
//   clock, reset : clock, synchronous active-high reset
//   push/push_tag: enqueue a tag
//   pop          : dequeue the head tag
//   set_err      : set err on the most recently pushed entry still queued
//   head         : head entry (valid when !empty)
//   empty        : queue holds no entries
module fft256_tag_fifo
  import fft256_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  tag_t push_tag,
  input  logic pop,
  input  logic set_err,
  output tag_t head,
  output logic empty
);

  tag_t       mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       full;
  logic       do_push;
  logic       do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= ~wr_ptr;
      end
      // Newest entry sits just behind the write pointer.
      if (set_err && !empty) mem[~wr_ptr].err <= 1'b1;
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  a_no_push_full: assert property (@(posedge clock) disable iff (reset) !(push && full));

endmodule

// File: rtl/fft256_frame_ctrl.sv
// Frame sequencer around the 256-point SDF first stage.
//   clock, reset              : clock, synchronous active-high reset
//   in_valid/in_sof/in_re/im  : upstream sample stream, in_ready accepts
//   stg_di_*                  : stage input (exactly 256 contiguous per frame)
//   stg_do_*                  : stage output
//   out_valid/re/im/sof/eof   : tagged output stream, one register behind stg_do_*
//   out_idx, out_err          : frame index and aborted flag (err valid with eof)
//   busy                      : sequencer not idle
//   abort_cnt                 : saturating abort count
module fft256_frame_ctrl
  import fft256_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned IDX_W        = 8,
  parameter int unsigned FLUSH_CYCLES = 260
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [WIDTH-1:0]  in_re,
  input  logic [WIDTH-1:0]  in_im,
  output logic              in_ready,
  output logic              stg_di_en,
  output logic [WIDTH-1:0]  stg_di_re,
  output logic [WIDTH-1:0]  stg_di_im,
  input  logic              stg_do_en,
  input  logic [WIDTH-1:0]  stg_do_re,
  input  logic [WIDTH-1:0]  stg_do_im,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_re,
  output logic [WIDTH-1:0]  out_im,
  output logic              out_sof,
  output logic              out_eof,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_err,
  output logic              busy,
  output logic [15:0]       abort_cnt
);

  localparam int unsigned FL_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [7:0]  S_PUSH  = 8'(HALF_N - 1);
  localparam logic [7:0]  S_LAST  = 8'(FFT_N - 1);
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_CYCLES - 1);

  state_t            state, state_nx;
  logic [7:0]        s_cnt;
  logic [FL_W-1:0]   flush_cnt;
  logic [IDX_W-1:0]  frame_cnt;
  logic [IDX_W-1:0]  cur_idx;
  logic [7:0]        o_cnt;
  logic              start;
  logic              push;
  logic              set_err;
  logic              pop;
  logic              head_ok;
  tag_t              push_tag;
  tag_t              q_head;
  logic              q_empty;

  assign stg_di_re = in_re;
  assign stg_di_im = in_im;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    stg_di_en = 1'b0;
    start     = 1'b0;
    push      = 1'b0;
    set_err   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && in_sof) begin
          stg_di_en = 1'b1;
          start     = 1'b1;
          state_nx  = RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        // A mid-frame sof is taken but dropped, and kills the frame.
        if (!in_valid || in_sof) begin
          state_nx = ABORT;
        end else begin
          stg_di_en = 1'b1;
          if (s_cnt == S_PUSH) push = 1'b1;
          if (s_cnt == S_LAST) state_nx = IDLE;
        end
      end
      ABORT: begin
        // s_cnt >= 128 means this frame already queued a tag.
        set_err  = s_cnt[7];
        state_nx = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt == FL_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      s_cnt     <= '0;
      flush_cnt <= '0;
      frame_cnt <= '0;
      cur_idx   <= '0;
      abort_cnt <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        s_cnt     <= 8'd1;
        cur_idx   <= frame_cnt;
        frame_cnt <= frame_cnt + 1'b1;
      end else if (stg_di_en) begin
        s_cnt <= s_cnt + 8'd1;
      end
      flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
      if (state == ABORT && abort_cnt != '1) abort_cnt <= abort_cnt + 16'd1;
    end
  end

  assign push_tag.idx = TAG_IDX_W'(cur_idx);
  assign push_tag.err = 1'b0;

  fft256_tag_fifo u_tag_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_tag (push_tag),
    .pop      (pop),
    .set_err  (set_err),
    .head     (q_head),
    .empty    (q_empty)
  );

  assign head_ok = stg_do_en & ~q_empty;
  assign pop     = head_ok & (o_cnt == S_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      o_cnt     <= '0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_idx   <= '0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= head_ok;
      out_re    <= stg_do_re;
      out_im    <= stg_do_im;
      out_sof   <= head_ok & (o_cnt == 8'd0);
      out_eof   <= pop;
      out_idx   <= IDX_W'(q_head.idx);
      out_err   <= q_head.err;
      if (head_ok) o_cnt <= o_cnt + 8'd1;
    end
  end

  a_do_en_has_tag: assert property (@(posedge clock) disable iff (reset) stg_do_en |-> !q_empty);

endmodule

// File: tb/tb_fft256_frame_ctrl.sv
// Randomized bench for fft256_frame_ctrl with a frame-level reference model
// and a simple stage stand-in that emits 256 samples per committed frame.
module tb_fft256_frame_ctrl;

  localparam int unsigned WIDTH        = 16;
  localparam int unsigned IDX_W        = 8;
  localparam int unsigned FLUSH_CYCLES = 260;
  localparam int          STG_LAT      = 40;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid, in_sof;
  logic [WIDTH-1:0]  in_re, in_im;
  logic              in_ready;
  logic              stg_di_en;
  logic [WIDTH-1:0]  stg_di_re, stg_di_im;
  logic              stg_do_en;
  logic [WIDTH-1:0]  stg_do_re, stg_do_im;
  logic              out_valid;
  logic [WIDTH-1:0]  out_re, out_im;
  logic              out_sof, out_eof;
  logic [IDX_W-1:0]  out_idx;
  logic              out_err;
  logic              busy;
  logic [15:0]       abort_cnt;

  always #5 clock = ~clock;

  fft256_frame_ctrl #(
    .WIDTH        (WIDTH),
    .IDX_W        (IDX_W),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_ready  (in_ready),
    .stg_di_en (stg_di_en),
    .stg_di_re (stg_di_re),
    .stg_di_im (stg_di_im),
    .stg_do_en (stg_do_en),
    .stg_do_re (stg_do_re),
    .stg_do_im (stg_do_im),
    .out_valid (out_valid),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .out_idx   (out_idx),
    .out_err   (out_err),
    .busy      (busy),
    .abort_cnt (abort_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame-level view of the controller.
  typedef struct {
    int idx;
    bit err;
    int start;
  } ofrm_t;

  int    cyc;
  bit    m_run;        // inside a frame
  int    m_cnt;        // samples accepted in the current frame
  int    m_block;      // remaining not-ready cycles after an abort
  int    m_next_idx;
  int    m_cur_idx;
  int    m_aborts;
  ofrm_t frames[$];    // frames the stage has committed to emit
  int    emit_pos;
  bit    e_valid, e_sof, e_eof, e_err;
  int    e_idx;
  logic [WIDTH-1:0] e_re, e_im;

  task automatic model_clear();
    m_run = 0; m_cnt = 0; m_block = 0; m_next_idx = 0; m_cur_idx = 0; m_aborts = 0;
    frames.delete();
    emit_pos = 0;
    e_valid = 0; e_sof = 0; e_eof = 0; e_err = 0; e_idx = 0; e_re = '0; e_im = '0;
  endtask

  task automatic step(input bit v, input bit sof);
    bit exp_ready, exp_den, exp_busy;
    in_valid  = v;
    in_sof    = sof;
    in_re     = WIDTH'($urandom);
    in_im     = WIDTH'($urandom);
    stg_do_re = WIDTH'($urandom);
    stg_do_im = WIDTH'($urandom);
    stg_do_en = (frames.size() > 0 && cyc >= frames[0].start);
    @(negedge clock);

    exp_ready = (m_block == 0);
    exp_busy  = m_run || (m_block > 0);
    exp_den   = 0;
    if (m_block > 0) begin
      m_block--;
    end else if (!m_run) begin
      if (v && sof) begin
        exp_den    = 1;
        m_run      = 1;
        m_cnt      = 1;
        m_cur_idx  = m_next_idx;
        m_next_idx = (m_next_idx + 1) % (1 << IDX_W);
      end
    end else if (!v || sof) begin
      m_run   = 0;
      m_block = FLUSH_CYCLES + 1;
      m_aborts++;
      if (m_cnt >= 128 && frames.size() > 0) frames[frames.size()-1].err = 1'b1;
    end else begin
      exp_den = 1;
      if (m_cnt == 127) frames.push_back('{idx: m_cur_idx, err: 1'b0, start: cyc + STG_LAT});
      m_cnt++;
      if (m_cnt == 256) m_run = 0;
    end

    check_val("in_ready", in_ready, exp_ready);
    check_val("busy", busy, exp_busy);
    check_val("di_en", stg_di_en, exp_den);
    if (exp_den) begin
      check_val("di_re", stg_di_re, in_re);
      check_val("di_im", stg_di_im, in_im);
    end
    check_val("out_valid", out_valid, e_valid);
    if (e_valid) begin
      check_val("out_sof", out_sof, e_sof);
      check_val("out_eof", out_eof, e_eof);
      check_val("out_idx", out_idx, e_idx);
      check_val("out_re", out_re, e_re);
      check_val("out_im", out_im, e_im);
      if (e_eof) check_val("out_err", out_err, e_err);
    end

    if (stg_do_en) begin
      e_valid = 1;
      e_sof   = (emit_pos == 0);
      e_eof   = (emit_pos == 255);
      e_idx   = frames[0].idx;
      e_err   = frames[0].err;
      e_re    = stg_do_re;
      e_im    = stg_do_im;
      emit_pos++;
      if (emit_pos == 256) begin
        emit_pos = 0;
        void'(frames.pop_front());
      end
    end else begin
      e_valid = 0;
    end

    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    stg_do_en = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc++;
    model_clear();
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_abort_cnt", abort_cnt, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_eof", out_eof, 0);
  endtask

  task automatic send_frame(input int n_good, input int ending);
    for (int i = 0; i < n_good; i++) step(1'b1, i == 0);
    if (ending == 1) step(1'b0, 1'b0);
    else if (ending == 2) step(1'b1, 1'b1);
  endtask

  task automatic idle(input int n, input bit noise);
    for (int i = 0; i < n; i++) step(noise ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
  endtask

  task automatic drain();
    int guard = 0;
    while ((frames.size() > 0 || m_block > 0 || e_valid) && guard < 3000) begin
      step(1'b0, 1'b0);
      guard++;
    end
    check_val("drain_bound", guard >= 3000, 0);
  endtask

  initial begin
    in_re = '0; in_im = '0; stg_do_re = '0; stg_do_im = '0;
    cyc = 0;
    model_clear();
    do_reset();
    idle(3, 1'b0);

    // single frame, then three back-to-back
    send_frame(256, 0);
    drain();
    for (int k = 0; k < 3; k++) send_frame(256, 0);
    drain();

    // early underrun: no output frame, next frame continues the index
    send_frame($urandom_range(1, 127), 1);
    idle(FLUSH_CYCLES + 5, 1'b1);
    check_val("abort_cnt_early", abort_cnt, m_aborts);
    send_frame(256, 0);
    drain();

    // late underrun: tagged err, following good frame clean
    send_frame($urandom_range(128, 255), 1);
    idle(FLUSH_CYCLES + 5, 1'b1);
    send_frame(256, 0);
    drain();
    check_val("abort_cnt_late", abort_cnt, m_aborts);

    // stray valid data while idle, then sof mid-frame
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    send_frame(100, 2);
    idle(FLUSH_CYCLES + 5, 1'b0);
    check_val("abort_cnt_sof", abort_cnt, m_aborts);

    // random mix
    for (int k = 0; k < 4; k++) begin
      case ($urandom_range(0, 2))
        0: send_frame(256, 0);
        1: begin send_frame($urandom_range(1, 255), 1); idle(FLUSH_CYCLES + 2, 1'b1); end
        default: begin send_frame($urandom_range(2, 255), 2); idle(FLUSH_CYCLES + 2, 1'b1); end
      endcase
      idle($urandom_range(0, 3), 1'b1);
    end
    drain();
    check_val("abort_cnt_mix", abort_cnt, m_aborts);

    // reset mid-frame while the stage is emitting
    send_frame(180, 0);
    do_reset();
    send_frame(256, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft256_frame_ctrl.md
Name: fft256_frame_ctrl

Overview:
- Frame sequencer in front of, and behind, the 256-point radix-2^2 SDF first stage (FFT256Stg1).
- Accepts a valid/ready sample stream with start-of-frame marks and drives the stage's di_en for exactly 256 contiguous samples per frame.
- Aborts and flushes on input underrun.
- Counts the stage's do_en stream to tag output frames with sof/eof, frame index and error status.

Parameters:
- WIDTH, 16, sample width per real/imag component.
- IDX_W, 8, width of the frame index counter.
- FLUSH_CYCLES, 260, idle cycles forced after an abort before a new frame may start.

Ports:
- clock  in  1  master clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream sample valid
- in_sof  in  1  first sample of a frame; qualified by in_valid
- in_re, in_im  in  WIDTH each  upstream sample
- in_ready  out  1  controller accepts the sample this cycle
- stg_di_en, stg_di_re, stg_di_im  out  1/WIDTH/WIDTH  to stage input
- stg_do_en, stg_do_re, stg_do_im  in  1/WIDTH/WIDTH  from stage output
- out_valid, out_re, out_im  out  1/WIDTH/WIDTH  tagged output stream
- out_sof, out_eof  out  1  first/last output sample of a frame
- out_idx  out  IDX_W  frame index of the current output frame
- out_err  out  1  valid with out_eof; frame was aborted
- busy  out  1  state != IDLE
- abort_cnt  out  16  saturating abort count

Behaviour:
- Reset (synchronous): state IDLE; all counters 0; tag queue empty; all outputs 0.
- stg_di_re/im are combinational copies of in_re/im.
- stg_di_en = in_valid & in_ready & (state is RUN, or IDLE with in_sof).
- No back-pressure toward the stage; out_* follows stg_do_* with one register of latency.
- States:
  - IDLE: in_ready=1. in_valid without in_sof is accepted and discarded. in_valid & in_sof -> RUN, sample count s=1, frame index latched.
  - RUN: in_ready=1; each accepted sample increments s.
    - Accepting sample s=255 (the 256th) -> IDLE. A same-cycle in_sof on the next cycle starts the next frame back-to-back with no gap.
    - in_valid=0 in RUN is an underrun -> ABORT.
    - in_sof mid-frame is also an abort. That sample is dropped and does not restart a frame.
  - ABORT (1 cycle): in_ready=0. Marks the in-flight tag (if any) err; abort_cnt+1, saturating at 16'hFFFF. -> FLUSH.
  - FLUSH: in_ready=0 for FLUSH_CYCLES cycles, then -> IDLE.
- Tag queue: 2 entries {idx, err}.
  - An entry is pushed when sample 128 (s=127) of a frame is accepted. This is the point at which the stage commits to emitting an output frame.
  - Aborts before s=127 push nothing; that frame produces no output.
  - Push when the queue is full is impossible by construction. The assertion must flag it.
- Output side: counter o counts cycles with stg_do_en=1.
  - out_sof when o=0.
  - out_eof when o=255; o wraps to 0, and the head tag pops on eof.
  - out_idx and out_err come from the head tag.
  - err can still be set while that frame is emitting, so out_err is sampled at eof.
  - stg_do_en with the queue empty: out_valid=0 and an assertion fires.
- Frame index increments on every frame start, including aborted frames, and wraps modulo 2^IDX_W.
- Reset mid-frame: state IDLE immediately. The stage's own reset is external; the controller makes no attempt to drain.

Decomposition:
- Package fft256_pkg holds: FFT_N=256, HALF_N=128, state enum {IDLE, RUN, ABORT, FLUSH}, and the tag struct {idx, err}.
- One sub-module, fft256_tag_fifo: 2-deep FIFO with an "err-set" write port aimed at the newest entry.

Test Plan:
- Single frame: sof plus 256 contiguous samples (re=n, im=0) -> stg_di_en high for exactly 256 cycles. 256 out_valid with out_sof on the first, out_eof on the last, out_idx=0, out_err=0.
- Back-to-back: 3 frames with no gap -> stg_di_en high for 768 cycles. Three output frames with idx 0,1,2, no out_err, no output gaps beyond the stage's own.
- Early underrun: in_valid drops at s=50 -> ABORT, in_ready=0 for 261 cycles, no output frame, abort_cnt=1. The next frame gets idx=1.
- Late underrun: in_valid drops at s=200 -> output frame emitted with out_eof and out_err=1. The following good frame has out_err=0.
- Stray data: in_valid without sof in IDLE for 10 cycles -> stg_di_en stays 0. Sof mid-frame at s=100 -> abort, abort_cnt+1.
- Reset at s=180 -> the next cycle has in_ready=1, busy=0, queue empty, abort_cnt=0.
